// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: converts a valid/ready command into a single APB transfer.
// Only one transfer is in flight at a time. The result comes back on a
// valid/ready response channel. A slave that never raises pready is abandoned
// after TIMEOUT_CYC ACCESS cycles and reported with rsp_err=1 and rsp_timeout=1.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  input  logic        cmd_prot,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB requester side
  output logic [15:0] paddr,
  output logic        pprot,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  // The wait counter must be at least one bit wide, even when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  // The counter value seen during the last permitted stalled ACCESS cycle.
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);
  localparam bit TIMEOUT_ON = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          limit_hit;

  // Flags the ACCESS cycle that would be the last one allowed without pready.
  assign limit_hit = TIMEOUT_ON && (wait_cnt == LIMIT);

  // Transfer sequencer. Every output is a register, so APB and response
  // signals never glitch. The APB address/control fields hold their last
  // values between transfers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pprot       <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            pstrb     <= cmd_write ? cmd_strb : 4'b0000;
            pprot     <= cmd_prot;
            wait_cnt  <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? 32'h0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (limit_hit) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl. It contains a responsive APB slave and a
// transaction-level model of the expected phases and responses. The
// stimulus is a set of directed transfers followed by a randomized stream.
module tb_apb_master_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb_master_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: the transfer currently owned by the DUT and its expected result.
  logic [31:0] model_mem [64];
  logic [31:0] slave_mem [64];
  bit          in_flight = 0;
  bit          have_cur = 0;
  bit          have_rsp = 0;
  bit          cur_write;
  logic [15:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_strb;
  bit          cur_prot;
  logic [31:0] exp_rdata;
  bit          exp_err;
  bit          exp_to;
  int          n_acc = 1;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          edges_since_reset = 0;
  int          acc_count = 0;
  int          rv_k = 0;
  int          rsp_seen = 0;
  int          rsp_expected = 0;
  logic [31:0] last_rdata;
  bit          last_err;
  bit          last_to;
  int          cur_waits = 0;
  bit          cur_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) edges_since_reset <= 0;
    else if (edges_since_reset < 3) edges_since_reset <= edges_since_reset + 1;
  end

  // APB slave: stalls for cur_waits ACCESS cycles, then completes. Outside
  // ACCESS it drives junk on pready/prdata/pslverr, which the DUT must ignore.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (psel && penable) begin
        pready  = (acc_cnt >= cur_waits);
        prdata  = slave_mem[int'(paddr[7:2])];
        pslverr = cur_err;
        if (pready && pwrite)
          for (int b = 0; b < 4; b++)
            if (pstrb[b]) slave_mem[int'(paddr[7:2])][8*b +: 8] = pwdata[8*b +: 8];
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end
  end

  // Compare process: on every falling edge out of reset, check the DUT
  // against the phase timing and response implied by the current transfer.
  initial begin
    int k;
    bit e_psel, e_pen, e_rv, e_rdy;
    forever begin
      @(negedge clk);
      if (rstn) begin
        k      = cyc - accept_cyc + 1;
        e_psel = in_flight && (k >= 1) && (k <= 1 + n_acc);
        e_pen  = in_flight && (k >= 2) && (k <= 1 + n_acc);
        e_rv   = in_flight && (k >= 2 + n_acc);
        e_rdy  = !in_flight && (edges_since_reset > 0);
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
        checkOutput("psel", 32'(psel), 32'(e_psel));
        checkOutput("penable", 32'(penable), 32'(e_pen));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (have_cur) begin
          checkOutput("paddr", 32'(paddr), 32'(cur_addr));
          checkOutput("pwrite", 32'(pwrite), 32'(cur_write));
          checkOutput("pwdata", pwdata, cur_wdata);
          checkOutput("pstrb", 32'(pstrb), 32'(cur_write ? cur_strb : 4'b0000));
          checkOutput("pprot", 32'(pprot), 32'(cur_prot));
        end else begin
          checkOutput("apb_fields_zero", {paddr, 11'b0, pstrb, pwrite, pprot}, 32'h0);
          checkOutput("pwdata_zero", pwdata, 32'h0);
        end
        if (rsp_valid) begin
          checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
          checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
          checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        end else if (!have_rsp) begin
          checkOutput("rsp_fields_zero", rsp_rdata | {30'b0, rsp_err, rsp_timeout}, 32'h0);
        end
        if (in_flight && penable) acc_count++;
        if (in_flight && rsp_valid && rv_k == 0) rv_k = k;
        if (rsp_valid && rsp_ready) begin
          rsp_seen++;
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          last_to    = rsp_timeout;
          have_rsp   = 1;
        end
      end
    end
  end

  // Present one command and wait until it is accepted. The model updates
  // its expectation at the acceptance edge. Call this only at posedge+1.
  task automatic sendCmd(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit prot, input int waits,
                         input bit err, output bit ok);
    bit timed_out;
    int idx;
    cur_waits = waits;
    cur_err   = err;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin @(posedge clk); #1; end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      ok = 0;
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
    cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 1'($urandom);
    timed_out = (waits >= TMO);
    idx       = int'(addr[7:2]);
    n_acc     = timed_out ? TMO : waits + 1;
    exp_to    = timed_out;
    exp_err   = timed_out ? 1'b1 : err;
    exp_rdata = (timed_out || wr) ? 32'h0 : model_mem[idx];
    if (!timed_out && wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    cur_write = wr; cur_addr = addr; cur_wdata = wdata; cur_strb = strb; cur_prot = prot;
    have_cur   = 1;
    accept_cyc = cyc;
    acc_count  = 0;
    rv_k       = 0;
    in_flight  = 1;
    ok = 1;
  endtask

  // Run one complete transfer. The response is held back for 'delay' cycles.
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input bit prot, input int waits,
                               input bit err, input int delay);
    bit ok;
    sendCmd(wr, addr, wdata, strb, prot, waits, err, ok);
    if (!ok) return;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin @(posedge clk); #1; end
    if (!rsp_valid) begin
      checkOutput("rsp_valid_wait", 32'(rsp_valid), 32'h1);
      in_flight = 0;
      return;
    end
    repeat (delay) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    in_flight = 0;
    rsp_expected++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int seen_before;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end

    // Reset state: every output is low while rstn is held low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("rst_psel_penable", {30'b0, psel, penable}, 32'h0);
    checkOutput("rst_paddr_pstrb", {paddr, 11'b0, pstrb, pwrite, pprot}, 32'h0);
    checkOutput("rst_pwdata", pwdata, 32'h0);
    checkOutput("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    rstn = 1'b1;
    #1;
    checkOutput("cmd_ready_before_edge", 32'(cmd_ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("cmd_ready_first_edge", 32'(cmd_ready), 32'h1);

    // Zero-wait write then read back.
    applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0, 0);
    checkOutput("wr_latency", 32'(rv_k), 32'd3);
    checkOutput("wr_err", 32'(last_err), 32'h0);
    applyStimulus(1'b0, 16'h0010, 32'h12345678, 4'hA, 1'b1, 0, 1'b0, 0);
    checkOutput("rd_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("rd_err", 32'(last_err), 32'h0);
    checkOutput("rd_latency", 32'(rv_k), 32'd3);

    // Three wait states: penable is high for four cycles and no timeout occurs.
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 3, 1'b0, 1);
    checkOutput("wait_acc_cycles", 32'(acc_count), 32'd4);
    checkOutput("wait_timeout", 32'(last_to), 32'h0);
    checkOutput("wait_rdata", last_rdata, 32'hDEADBEEF);

    // Slave error on a read.
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 0, 1'b1, 0);
    checkOutput("slverr_err", 32'(last_err), 32'h1);
    checkOutput("slverr_timeout", 32'(last_to), 32'h0);
    checkOutput("slverr_rdata", last_rdata, 32'hDEADBEEF);

    // Slave never ready: abort after exactly TMO ACCESS cycles.
    applyStimulus(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 1'b0, 10, 1'b0, 0);
    checkOutput("tmo_acc_cycles", 32'(acc_count), 32'd4);
    checkOutput("tmo_err", 32'(last_err), 32'h1);
    checkOutput("tmo_flag", 32'(last_to), 32'h1);
    checkOutput("tmo_rdata", last_rdata, 32'h0);

    // Response back-pressure for five cycles.
    seen_before = rsp_seen;
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 1, 1'b0, 5);
    checkOutput("bp_one_response", 32'(rsp_seen - seen_before), 32'h1);
    checkOutput("bp_rdata", last_rdata, 32'h0);

    // Asynchronous reset in the middle of ACCESS.
    sendCmd(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 3, 1'b0, ok);
    @(posedge clk);
    #1;
    checkOutput("mid_penable", 32'(penable), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_psel", 32'(psel), 32'h0);
    checkOutput("async_penable", 32'(penable), 32'h0);
    checkOutput("async_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("async_cmd_ready", 32'(cmd_ready), 32'h0);
    in_flight = 0; have_cur = 0; have_rsp = 0;
    seen_before = rsp_seen;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no_rsp_after_reset", 32'(rsp_seen), 32'(seen_before));
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0);
    checkOutput("post_reset_latency", 32'(rv_k), 32'd3);
    checkOutput("post_reset_rdata", last_rdata, 32'hDEADBEEF);

    // Randomized stream with timeouts, errors, waits and back-pressure.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 1'($urandom),
                    $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    checkOutput("response_count", 32'(rsp_seen), 32'(rsp_expected));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, max ACCESS cycles without pready before abort; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-005 SHALL have ports cmd_write input 1, cmd_addr input 16, cmd_wdata input 32, cmd_strb input 4, cmd_prot input 1: command fields.
REQ-006 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-007 SHALL have ports rsp_rdata output 32, rsp_err output 1, rsp_timeout output 1: response fields.
REQ-008 SHALL have APB outputs paddr 16, pprot 1, psel 1, penable 1, pwrite 1, pwdata 32, pstrb 4.
REQ-009 SHALL have APB inputs pready 1, prdata 32, pslverr 1.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; one transaction in flight; no internal queue.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on an edge with cmd_valid=1 and cmd_ready=1, and the FSM moves IDLE->SETUP.
REQ-012 SHALL register all command fields on acceptance; APB outputs come only from the registered copy.
REQ-013 SETUP: psel=1, penable=0, for exactly one cycle, then ACCESS.
REQ-014 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb/pprot stable from SETUP through the end of ACCESS.
REQ-015 SHALL drive pstrb=4'b0000 on reads and pstrb=cmd_strb on writes; pwdata on reads holds the registered value.
REQ-016 pready SHALL be sampled only in ACCESS; pready, prdata and pslverr are ignored in every other state.
REQ-017 ACCESS with pready=1: capture rsp_rdata=prdata for reads or 0 for writes, rsp_err=pslverr, rsp_timeout=0; next state is RESP.
REQ-018 SHALL count ACCESS cycles with pready=0 in a counter of width clog2(TIMEOUT_CYC+1); the counter clears on entry to SETUP.
REQ-019 When TIMEOUT_CYC!=0 and the TIMEOUT_CYC-th consecutive ACCESS cycle has pready=0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, next state RESP.
REQ-020 If pready=1 in the same cycle the timeout limit is reached, SHALL treat it as normal completion; pready wins.
REQ-021 RESP: psel=0, penable=0, rsp_valid=1, and rsp_* held stable until rsp_ready=1; then IDLE.
REQ-022 Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS from N+2, rsp_valid from N+3 when pready=1 in the first ACCESS cycle.
REQ-023 Back-to-back: RESP->IDLE on the rsp_ready edge; the next command is accepted one cycle later; psel is deasserted at least 2 cycles between transfers.
REQ-024 In IDLE and RESP, psel=penable=0 and paddr/pwrite/pwdata/pstrb/pprot hold the last transfer's values.

Reset
REQ-025 rstn=0 SHALL force, immediately and asynchronously, FSM=IDLE, counter=0, and all outputs 0 (psel, penable, paddr, pprot, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout), except cmd_ready, which is also 0 while rstn=0.
REQ-026 cmd_ready SHALL become 1 on the first rising clk edge after rstn deasserts.
REQ-027 Reset during SETUP, ACCESS or RESP SHALL abandon the transaction with no response produced; the first command after reset starts a clean SETUP.

Verification
REQ-028 Write then read with a zero-wait slave:
- write addr 0x0010, data 0xDEADBEEF, strb 0xF;
- then read 0x0010;
- required: rsp_rdata=0xDEADBEEF, rsp_err=0;
- required: read shows pstrb=0 and the SETUP/ACCESS phase order.
REQ-029 Wait states: slave holds pready=0 for 3 ACCESS cycles -> penable stays 1 for 4 cycles, paddr stays stable, one response, rsp_timeout=0.
REQ-030 Slave error: read with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
REQ-031 Timeout: TIMEOUT_CYC=4, pready stuck 0 -> after exactly 4 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-032 Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp fields stable, cmd_ready=0, psel=0 throughout; completion on the rsp_ready edge.
REQ-033 Reset mid-ACCESS: assert rstn=0 asynchronously -> psel, penable and rsp_valid go 0 without a clock edge; no response after release.
